adder_pipe: RTL and testbench

ADDER_PIPE -- requirements
Module: adder_pipe

---
 rtl/adder_pipe.sv | 120 ++++++++++++
 tb/tb_adder_pipe.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_pipe.sv
// rtl/adder_pipe.sv - chunked pipelined add/subtract with signed saturation and valid/ready flow
// Stage k adds chunk k of the operands with the carry registered by stage k-1.
module adder_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int C = WIDTH / STAGES;
  localparam int L = STAGES - 1;

  logic             advance;
  logic [WIDTH-1:0] eff_b;
  logic             eff_c;
  logic [WIDTH-1:0] raw;
  logic             a_msb;
  logic             b_msb;

  assign eff_b    = sub ? ~b : b;
  assign eff_c    = sub | cin;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int SRC = WIDTH - k * C;
    localparam int REM = SRC - C;

    logic [SRC-1:0]     src_a;
    logic [SRC-1:0]     src_b;
    logic               c_in;
    logic               sat_in;
    logic               am_in;
    logic               bm_in;
    logic               v_in;
    logic [C:0]         part;
    logic [(k+1)*C-1:0] res_d;
    logic [(k+1)*C-1:0] res_q;
    logic               v_q;
    logic               cy_q;
    logic               sat_q;
    logic               am_q;
    logic               bm_q;

    if (k == 0) begin : g_src
      assign src_a  = a;
      assign src_b  = eff_b;
      assign c_in   = eff_c;
      assign sat_in = sat;
      assign am_in  = a[WIDTH-1];
      assign bm_in  = eff_b[WIDTH-1];
      assign v_in   = in_valid;
      assign res_d  = part[C-1:0];
    end else begin : g_src
      assign src_a  = g_stg[k-1].g_rem.ra_q;
      assign src_b  = g_stg[k-1].g_rem.rb_q;
      assign c_in   = g_stg[k-1].cy_q;
      assign sat_in = g_stg[k-1].sat_q;
      assign am_in  = g_stg[k-1].am_q;
      assign bm_in  = g_stg[k-1].bm_q;
      assign v_in   = g_stg[k-1].v_q;
      assign res_d  = {part[C-1:0], g_stg[k-1].res_q};
    end

    // Only a C+1 bit adder per stage; the carry is the registered part[C].
    assign part = {1'b0, src_a[C-1:0]} + {1'b0, src_b[C-1:0]} + {{C{1'b0}}, c_in};

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q   <= 1'b0;
        cy_q  <= 1'b0;
        sat_q <= 1'b0;
        am_q  <= 1'b0;
        bm_q  <= 1'b0;
        res_q <= '0;
      end else if (advance) begin
        v_q   <= v_in;
        cy_q  <= part[C];
        sat_q <= sat_in;
        am_q  <= am_in;
        bm_q  <= bm_in;
        res_q <= res_d;
      end
    end

    if (REM > 0) begin : g_rem
      logic [REM-1:0] ra_q;
      logic [REM-1:0] rb_q;

      always_ff @(posedge clk) begin
        if (advance) begin
          ra_q <= src_a[SRC-1:C];
          rb_q <= src_b[SRC-1:C];
        end
      end
    end
  end

  assign raw       = g_stg[L].res_q;
  assign a_msb     = g_stg[L].am_q;
  assign b_msb     = g_stg[L].bm_q;
  assign out_valid = g_stg[L].v_q;
  assign cout      = g_stg[L].cy_q;
  assign ovf       = (a_msb == b_msb) && (raw[WIDTH-1] != a_msb);
  // Clamp toward the sign of A: 0x7F..F for positive, 0x80..0 for negative.
  assign sum       = (g_stg[L].sat_q && ovf) ? {a_msb, {(WIDTH-1){!a_msb}}} : raw;

endmodule

// File: tb/tb_adder_pipe.sv
// tb/tb_adder_pipe.sv - self-checking bench for adder_pipe against an arithmetic reference model
// Covers reset, directed corner cases, random backpressure, mid-flight reset and a width/stage sweep.
module tb_adder_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic        rst, in_valid, in_ready, cin, sub, sat, out_valid, out_ready, cout, ovf;
  logic [31:0] a, b, sum;

  adder_pipe #(.WIDTH(32), .STAGES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .sat(sat), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  logic        sw_rst, sw_valid, sw_cin, sw_sub, sw_sat;
  logic [63:0] sw_a, sw_b;
  logic [3:0]  sw_ir, sw_ov, sw_co, sw_of;
  logic [7:0]  s8;
  logic [15:0] s16;
  logic [31:0] s32;
  logic [63:0] s64;

  adder_pipe #(.WIDTH(8), .STAGES(1)) u_w8 (
    .clk(clk), .rst(sw_rst), .in_valid(sw_valid), .in_ready(sw_ir[0]), .a(sw_a[7:0]), .b(sw_b[7:0]),
    .cin(sw_cin), .sub(sw_sub), .sat(sw_sat), .out_valid(sw_ov[0]), .out_ready(1'b1),
    .sum(s8), .cout(sw_co[0]), .ovf(sw_of[0])
  );
  adder_pipe #(.WIDTH(16), .STAGES(2)) u_w16 (
    .clk(clk), .rst(sw_rst), .in_valid(sw_valid), .in_ready(sw_ir[1]), .a(sw_a[15:0]), .b(sw_b[15:0]),
    .cin(sw_cin), .sub(sw_sub), .sat(sw_sat), .out_valid(sw_ov[1]), .out_ready(1'b1),
    .sum(s16), .cout(sw_co[1]), .ovf(sw_of[1])
  );
  adder_pipe #(.WIDTH(32), .STAGES(8)) u_w32 (
    .clk(clk), .rst(sw_rst), .in_valid(sw_valid), .in_ready(sw_ir[2]), .a(sw_a[31:0]), .b(sw_b[31:0]),
    .cin(sw_cin), .sub(sw_sub), .sat(sw_sat), .out_valid(sw_ov[2]), .out_ready(1'b1),
    .sum(s32), .cout(sw_co[2]), .ovf(sw_of[2])
  );
  adder_pipe #(.WIDTH(64), .STAGES(4)) u_w64 (
    .clk(clk), .rst(sw_rst), .in_valid(sw_valid), .in_ready(sw_ir[3]), .a(sw_a), .b(sw_b),
    .cin(sw_cin), .sub(sw_sub), .sat(sw_sat), .out_valid(sw_ov[3]), .out_ready(1'b1),
    .sum(s64), .cout(sw_co[3]), .ovf(sw_of[3])
  );

  function automatic int sw_width(input int i);
    case (i)
      0:       return 8;
      1:       return 16;
      2:       return 32;
      default: return 64;
    endcase
  endfunction

  function automatic logic [63:0] sw_sum(input int i);
    case (i)
      0:       return 64'(s8);
      1:       return 64'(s16);
      2:       return 64'(s32);
      default: return s64;
    endcase
  endfunction

  function automatic logic [63:0] wmask(input int w);
    return (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  // Reference: true signed/unsigned arithmetic on w-bit values; returns {ovf, cout, sum}.
  function automatic logic [65:0] model(input int w, input logic [63:0] ai, input logic [63:0] bi,
                                        input logic ci, input logic su, input logic sa_en);
    logic [63:0]        m, s, av, bv;
    logic signed [66:0] sa, sb, t, maxv, minv;
    logic [64:0]        us;
    logic               co, ov;
    m  = wmask(w);
    av = ai & m;
    bv = bi & m;
    sa = $signed(67'(av));
    sb = $signed(67'(bv));
    if (av[w-1]) sa = sa - (67'sd1 <<< w);
    if (bv[w-1]) sb = sb - (67'sd1 <<< w);
    t    = su ? (sa - sb) : (sa + sb + $signed({66'd0, ci}));
    maxv = (67'sd1 <<< (w - 1)) - 67'sd1;
    minv = -(67'sd1 <<< (w - 1));
    ov   = (t > maxv) || (t < minv);
    us   = 65'(av) + 65'(bv) + 65'(ci);
    co   = su ? (av >= bv) : us[w];
    if (sa_en && ov) s = (t > maxv) ? (maxv[63:0] & m) : (minv[63:0] & m);
    else             s = t[63:0] & m;
    return {ov, co, s};
  endfunction

  task automatic rand_op(output logic [31:0] ra, output logic [31:0] rb,
                         output logic rc, output logic rs, output logic rt);
    case ($urandom_range(0, 3))
      0:       ra = 32'h7FFFFFFF;
      1:       ra = 32'h80000000;
      default: ra = $urandom;
    endcase
    rb = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
    rc = 1'($urandom_range(0, 1));
    rs = 1'($urandom_range(0, 1));
    rt = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; sw_rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    a = 32'h1234_5678; b = 32'h1; cin = 1'b0; sub = 1'b0; sat = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++;
    if ({sum, cout, ovf} !== 34'd0) begin
      n_fail++; $display("FAIL reset_outputs: got sum=%h cout=%b ovf=%b want all 0", sum, cout, ovf);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    rst = 1'b0; sw_rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) begin
      @(negedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_discard: got out_valid %b want 0", out_valid); end
    end
  endtask

  task automatic test_directed();
    logic [31:0] da [6] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'd5, 32'h0000FFFF};
    logic [31:0] db [6] = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd7, 32'd0};
    bit          dc [6] = '{0, 0, 0, 0, 0, 1};
    bit          ds [6] = '{0, 0, 0, 1, 1, 0};
    bit          dt [6] = '{0, 1, 0, 1, 0, 0};
    logic [31:0] es [6] = '{32'h0, 32'h7FFFFFFF, 32'h80000000, 32'h80000000, 32'hFFFFFFFE, 32'h00010000};
    bit          ec [6] = '{1, 0, 0, 1, 0, 0};
    bit          eo [6] = '{0, 1, 1, 1, 0, 0};
    int          lat;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'b1; out_ready = 1'b1;
      a = da[i]; b = db[i]; cin = dc[i]; sub = ds[i]; sat = dt[i];
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      #1;
      while (!out_valid && lat < 12) begin @(negedge clk); #1; lat++; end
      n_cmp++;
      if (lat !== 4) begin n_fail++; $display("FAIL directed%0d_latency: got %0d want 4", i, lat); end
      n_cmp++;
      if (sum !== es[i]) begin n_fail++; $display("FAIL directed%0d_sum: got %h want %h", i, sum, es[i]); end
      n_cmp++;
      if (cout !== ec[i]) begin n_fail++; $display("FAIL directed%0d_cout: got %b want %b", i, cout, ec[i]); end
      n_cmp++;
      if (ovf !== eo[i]) begin n_fail++; $display("FAIL directed%0d_ovf: got %b want %b", i, ovf, eo[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [65:0] exp_q [$];
    logic [65:0] e;
    logic [33:0] prev;
    logic        prev_stall = 1'b0;
    logic        pending = 1'b0;
    int          sent = 0, got = 0, cyc = 0;
    while (got < 10 && cyc < 400) begin
      @(negedge clk);
      out_ready = 1'($urandom_range(0, 1));
      if (!pending && sent < 10 && $urandom_range(0, 3) != 0) begin
        rand_op(a, b, cin, sub, sat);
        pending = 1'b1;
      end
      in_valid = pending;
      #1;
      n_cmp++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        n_fail++; $display("FAIL bp_in_ready: got %b want %b", in_ready, !(out_valid && !out_ready));
      end
      if (prev_stall) begin
        n_cmp++;
        if ({out_valid, sum, cout, ovf} !== {1'b1, prev}) begin
          n_fail++; $display("FAIL bp_stable: got %b_%h want 1_%h", out_valid, {sum, cout, ovf}, prev);
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL bp_extra_output: got sum %h want no output", sum);
        end else begin
          e = exp_q.pop_front();
          if ({ovf, cout, sum} !== {e[65:64], e[31:0]}) begin
            n_fail++; $display("FAIL bp_result%0d: got %h want %h", got, {ovf, cout, sum}, {e[65:64], e[31:0]});
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(32, 64'(a), 64'(b), cin, sub, sat));
        sent++;
        pending = 1'b0;
      end
      prev_stall = out_valid && !out_ready;
      prev = {sum, cout, ovf};
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    n_cmp++;
    if (got !== 10) begin n_fail++; $display("FAIL bp_count: got %0d want 10", got); end
  endtask

  task automatic test_reset_midflight();
    logic [65:0] e;
    int          lat;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; out_ready = 1'b1;
      rand_op(a, b, cin, sub, sat);
      if (i == 2) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    repeat (8) begin
      #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_flushed: got out_valid %b want 0", out_valid); end
      @(negedge clk);
    end
    in_valid = 1'b1;
    rand_op(a, b, cin, sub, sat);
    e = model(32, 64'(a), 64'(b), cin, sub, sat);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    #1;
    while (!out_valid && lat < 12) begin @(negedge clk); #1; lat++; end
    n_cmp++;
    if (lat !== 4) begin n_fail++; $display("FAIL midrst_latency: got %0d want 4", lat); end
    n_cmp++;
    if ({ovf, cout, sum} !== {e[65:64], e[31:0]}) begin
      n_fail++; $display("FAIL midrst_result: got %h want %h", {ovf, cout, sum}, {e[65:64], e[31:0]});
    end
  endtask

  task automatic test_sweep();
    logic [63:0] ta [24];
    logic [63:0] tb [24];
    logic [2:0]  tm [24];
    logic [65:0] e;
    logic [63:0] m;
    int          rd [4] = '{0, 0, 0, 0};
    int          idx = 0;
    int          w;
    for (int j = 0; j < 24; j++) begin
      ta[j] = {$urandom, $urandom};
      tb[j] = {$urandom, $urandom};
      if (j % 4 == 1) ta[j] = 64'h7F7F_FFFF_7FFF_FFFF;
      if (j % 4 == 2) ta[j] = 64'h8080_0000_8000_0000;
      if (j % 3 == 0) tb[j] = 64'(j % 3 + 1);
      tm[j] = 3'($urandom_range(0, 7));
    end
    for (int cyc = 0; cyc < 70; cyc++) begin
      @(negedge clk);
      if (idx < 24 && $urandom_range(0, 3) != 0) begin
        sw_valid = 1'b1;
        sw_a = ta[idx]; sw_b = tb[idx]; {sw_cin, sw_sub, sw_sat} = tm[idx];
      end else begin
        sw_valid = 1'b0;
      end
      #1;
      n_cmp++;
      if (sw_ir !== 4'hF) begin n_fail++; $display("FAIL sweep_in_ready: got %b want 1111", sw_ir); end
      for (int i = 0; i < 4; i++) begin
        if (sw_ov[i]) begin
          w = sw_width(i);
          m = wmask(w);
          n_cmp++;
          if (rd[i] >= 24) begin
            n_fail++; $display("FAIL sweep_w%0d_extra: got output %h want none", w, sw_sum(i));
          end else begin
            e = model(w, ta[rd[i]], tb[rd[i]], tm[rd[i]][2], tm[rd[i]][1], tm[rd[i]][0]);
            if ({sw_of[i], sw_co[i], sw_sum(i)} !== {e[65:64], e[63:0] & m}) begin
              n_fail++;
              $display("FAIL sweep_w%0d_op%0d: got %b%b_%h want %b_%h", w, rd[i], sw_of[i], sw_co[i],
                       sw_sum(i), e[65:64], e[63:0] & m);
            end
          end
          rd[i]++;
        end
      end
      if (sw_valid) idx++;
    end
    sw_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (rd[i] !== 24) begin n_fail++; $display("FAIL sweep_w%0d_count: got %0d want 24", sw_width(i), rd[i]); end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0; sat = 1'b0;
    sw_rst = 1'b1; sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_sub = 1'b0; sw_sat = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midflight();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
